// File: rtl/mem_access_ctrl_if.sv
// Bundle of EX/MEM controls, dcache handshake and MEM/WB results around mem_access_ctrl.
// master drives the pipeline/dcache side, slave is the controller.
interface mem_access_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              memRead_in;
  logic              memWrite_in;
  logic              llsc_in;
  logic              halt_in;
  logic [ADDR_W-1:0] ALUout_in;
  logic [DATA_W-1:0] storeData_in;
  logic              advance_in;
  logic              dhit;
  logic [DATA_W-1:0] dmemload;
  logic              snoop_inv_in;
  logic [ADDR_W-1:0] snoop_addr_in;
  logic              dmemREN;
  logic              dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic [DATA_W-1:0] dmemstore;
  logic [DATA_W-1:0] dmemload_out;
  logic              dhit_out;
  logic              stall_out;
  logic              err_timeout;

  modport master (
    output memRead_in, memWrite_in, llsc_in, halt_in, ALUout_in, storeData_in, advance_in,
    output dhit, dmemload, snoop_inv_in, snoop_addr_in,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, dmemload_out, dhit_out, stall_out,
    input  err_timeout
  );

  modport slave (
    input  memRead_in, memWrite_in, llsc_in, halt_in, ALUout_in, storeData_in, advance_in,
    input  dhit, dmemload, snoop_inv_in, snoop_addr_in,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, dmemload_out, dhit_out, stall_out,
    output err_timeout
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage dcache access controller: one request per instruction, held until dhit.
// Define LLSC_EN to add the LL/SC link register; without it SC behaves as a store returning 1.
module mem_access_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic              clk,
  input logic              nRST,
  mem_access_ctrl_if.slave mif
);

  typedef enum logic [0:0] {IDLE, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [DATA_W-1:0] load_q;
  logic [7:0]        wait_cnt;
  logic              err_q;

  logic              rd, wr, op, is_sc, sc_ok, sc_fail, done;
  logic [DATA_W-1:0] result;

  // Read wins when both controls are set.
  assign rd    = mif.memRead_in;
  assign wr    = mif.memWrite_in & ~mif.memRead_in;
  assign op    = (mif.memRead_in | mif.memWrite_in) & ~mif.halt_in;
  assign is_sc = mif.llsc_in & wr;

`ifdef LLSC_EN
  logic              link_v;
  logic [ADDR_W-1:0] link_addr;
  logic              snoop_hit;

  // A same-cycle snoop on the linked address beats the SC.
  assign snoop_hit = mif.snoop_inv_in & (mif.snoop_addr_in == link_addr);
  assign sc_ok     = link_v & (link_addr == mif.ALUout_in) & ~snoop_hit;
  assign sc_fail   = is_sc & ~sc_ok;
`else
  logic unused_snoop;
  assign unused_snoop = ^{mif.snoop_inv_in, mif.snoop_addr_in};
  assign sc_ok        = 1'b1;
  assign sc_fail      = 1'b0;
`endif

  // A failing SC completes locally without touching the dcache.
  assign done   = (state == IDLE) & op & (mif.dhit | sc_fail);
  assign result = is_sc ? DATA_W'(sc_ok) : mif.dmemload;

  always_comb begin
    mif.dmemREN      = 1'b0;
    mif.dmemWEN      = 1'b0;
    mif.dhit_out     = 1'b0;
    mif.stall_out    = 1'b0;
    mif.dmemload_out = load_q;
    mif.dmemaddr     = mif.ALUout_in;
    mif.dmemstore    = mif.storeData_in;
    mif.err_timeout  = err_q;
    if ((state == IDLE) && op) begin
      mif.dmemREN   = rd;
      mif.dmemWEN   = wr & ~sc_fail;
      mif.dhit_out  = done;
      mif.stall_out = ~done;
      if (done) mif.dmemload_out = result;
      if (sc_fail) mif.dmemstore = '0;
    end
    if (nRST) begin
      mif.dmemREN      = 1'b0;
      mif.dmemWEN      = 1'b0;
      mif.dhit_out     = 1'b0;
      mif.stall_out    = 1'b0;
      mif.dmemload_out = '0;
      mif.dmemaddr     = '0;
      mif.dmemstore    = '0;
      mif.err_timeout  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      state    <= IDLE;
      load_q   <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
`ifdef LLSC_EN
      link_v    <= 1'b0;
      link_addr <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (done) begin
            if (rd | is_sc) load_q <= result;
            wait_cnt <= '0;
            state    <= mif.advance_in ? IDLE : DONE;
          end else if (op) begin
            if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
            if ((TIMEOUT_CYC != 0) && (wait_cnt == TO_LAST)) err_q <= 1'b1;
          end else begin
            wait_cnt <= '0;
          end
        end
        DONE: begin
          wait_cnt <= '0;
          if (mif.advance_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef LLSC_EN
      if (snoop_hit) link_v <= 1'b0;
      if (done) begin
        if (rd & mif.llsc_in) begin
          link_v    <= 1'b1;
          link_addr <= mif.ALUout_in;
        end else if (wr & ~sc_fail & (is_sc | (mif.ALUout_in == link_addr))) begin
          link_v <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases with literal expectations, then random traffic
// compared every cycle against a transaction-level model.
module tb_mem_access_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  mem_access_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) mif ();

  mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk  (clk),
    .nRST (rst),
    .mif  (mif)
  );

  always #5 clk = ~clk;

  // Model: whether the current instruction's access is already done, last result, link, watchdog.
  bit          m_granted;
  logic [31:0] m_last;
  int          m_wait;
  bit          m_err;
  bit          m_link_v;
  logic [31:0] m_link_addr;

  logic        e_ren, e_wen, e_hit, e_stall, e_err;
  logic [31:0] e_load, e_addr, e_store;

  logic [31:0] pool [4] = '{32'h40, 32'h44, 32'h100, 32'h200};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_granted   = 1'b0;
    m_last      = '0;
    m_wait      = 0;
    m_err       = 1'b0;
    m_link_v    = 1'b0;
    m_link_addr = '0;
  endtask

  task automatic exp_calc();
    bit is_load, is_sc, sc_ok;
    e_ren   = 1'b0;
    e_wen   = 1'b0;
    e_hit   = 1'b0;
    e_stall = 1'b0;
    e_load  = m_last;
    e_addr  = mif.ALUout_in;
    e_store = mif.storeData_in;
    e_err   = m_err;
    if (rst) begin
      e_load  = '0;
      e_addr  = '0;
      e_store = '0;
      e_err   = 1'b0;
      return;
    end
    if (m_granted || !((mif.memRead_in || mif.memWrite_in) && !mif.halt_in)) return;
    is_load = mif.memRead_in;
    is_sc   = mif.llsc_in && !is_load;
`ifdef LLSC_EN
    sc_ok = m_link_v && (m_link_addr == mif.ALUout_in) &&
            !(mif.snoop_inv_in && (mif.snoop_addr_in == m_link_addr));
`else
    sc_ok = 1'b1;
`endif
    e_hit   = mif.dhit || (is_sc && !sc_ok);
    e_ren   = is_load;
    e_wen   = !is_load && !(is_sc && !sc_ok);
    e_stall = !e_hit;
    if (is_sc && !sc_ok) e_store = '0;
    if (e_hit) e_load = is_sc ? (sc_ok ? 32'd1 : 32'd0) : mif.dmemload;
  endtask

  // Applies the effect of the clock edge given the inputs held during the cycle.
  task automatic step_model();
    bit is_mem, is_sc;
    exp_calc();
    is_mem = (mif.memRead_in || mif.memWrite_in) && !mif.halt_in;
    is_sc  = mif.llsc_in && !mif.memRead_in;
`ifdef LLSC_EN
    if (mif.snoop_inv_in && (mif.snoop_addr_in == m_link_addr)) m_link_v = 1'b0;
`endif
    if (m_granted) begin
      m_wait = 0;
      if (mif.advance_in) m_granted = 1'b0;
    end else if (!is_mem) begin
      m_wait = 0;
    end else if (e_hit) begin
      if (mif.memRead_in || is_sc) m_last = e_load;
`ifdef LLSC_EN
      if (mif.memRead_in && mif.llsc_in) begin
        m_link_v    = 1'b1;
        m_link_addr = mif.ALUout_in;
      end else if (e_wen && (is_sc || mif.ALUout_in == m_link_addr)) begin
        m_link_v = 1'b0;
      end
`endif
      m_granted = !mif.advance_in;
      m_wait    = 0;
    end else begin
      if (m_wait == int'(TO) - 1) m_err = 1'b1;
      if (m_wait < 255) m_wait++;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      exp_calc();
      check("dmemREN", 32'(mif.dmemREN), 32'(e_ren));
      check("dmemWEN", 32'(mif.dmemWEN), 32'(e_wen));
      check("dhit_out", 32'(mif.dhit_out), 32'(e_hit));
      check("stall_out", 32'(mif.stall_out), 32'(e_stall));
      check("dmemload_out", mif.dmemload_out, e_load);
      check("dmemaddr", mif.dmemaddr, e_addr);
      check("dmemstore", mif.dmemstore, e_store);
      check("err_timeout", 32'(mif.err_timeout), 32'(e_err));
    end
  end

  task automatic set_op(input bit rd, input bit wr, input bit ll, input bit hl,
                        input logic [31:0] addr, input logic [31:0] data);
    mif.memRead_in   = rd;
    mif.memWrite_in  = wr;
    mif.llsc_in      = ll;
    mif.halt_in      = hl;
    mif.ALUout_in    = addr;
    mif.storeData_in = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_instr();
    int k;
    k = int'($urandom_range(0, 9));
    set_op(k <= 2 || k == 5 || k == 7, (k >= 3 && k <= 4) || k == 6 || k == 7, k == 5 || k == 6,
           $urandom_range(0, 9) == 0, pool[$urandom_range(0, 3)], $urandom);
  endtask

  initial begin
    int  wen_cnt;
    bit  adv_seen;
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
    mif.advance_in    = 1'b0;
    mif.dhit          = 1'b0;
    mif.dmemload      = '0;
    mif.snoop_inv_in  = 1'b0;
    mif.snoop_addr_in = '0;

    // Outputs are forced low while reset is held, even with a load presented.
    #2;
    check("rst_ren", 32'(mif.dmemREN), 32'd0);
    check("rst_stall", 32'(mif.stall_out), 32'd0);
    check("rst_addr", mif.dmemaddr, 32'd0);
    check("rst_load", mif.dmemload_out, 32'd0);
    check("rst_err", 32'(mif.err_timeout), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Load 0x100 hit on the third cycle.
    @(negedge clk);
    check("ld_c1_stall", 32'(mif.stall_out), 32'd1);
    check("ld_c1_ren", 32'(mif.dmemREN), 32'd1);
    check("ld_c1_addr", mif.dmemaddr, 32'h100);
    tick();
    @(negedge clk);
    check("ld_c2_stall", 32'(mif.stall_out), 32'd1);
    tick();
    mif.dhit = 1'b1;
    mif.dmemload = 32'hDEADBEEF;
    @(negedge clk);
    check("ld_c3_stall", 32'(mif.stall_out), 32'd0);
    check("ld_c3_dhit", 32'(mif.dhit_out), 32'd1);
    check("ld_c3_data", mif.dmemload_out, 32'hDEADBEEF);
    tick();
    mif.dhit = 1'b0;
    mif.dmemload = 32'h0;
    @(negedge clk);
    check("ld_done_ren", 32'(mif.dmemREN), 32'd0);
    check("ld_done_dhit", 32'(mif.dhit_out), 32'd0);
    check("ld_done_data", mif.dmemload_out, 32'hDEADBEEF);
    mif.advance_in = 1'b1;
    tick();
    mif.advance_in = 1'b0;

    // Store 0x200, pipeline held for several cycles after the hit: a single write.
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h1234);
    mif.dhit = 1'b1;
    wen_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) check("st_dhit", 32'(mif.dhit_out), 32'd1);
      wen_cnt += int'(mif.dmemWEN);
      tick();
      mif.dhit = 1'b0;
    end
    check("st_wen_count", 32'(wen_cnt), 32'd1);
    check("st_done_stall", 32'(mif.stall_out), 32'd0);
    mif.advance_in = 1'b1;
    tick();
    mif.advance_in = 1'b0;

    // Reset pulse during an outstanding load clears load_q and reissues the request.
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0);
    @(negedge clk);
    check("rl_ren_pre", 32'(mif.dmemREN), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rl_ren_rst", 32'(mif.dmemREN), 32'd0);
    check("rl_stall_rst", 32'(mif.stall_out), 32'd0);
    check("rl_load_rst", mif.dmemload_out, 32'd0);
    #1 rst = 1'b0;
    #1;
    check("rl_ren_after", 32'(mif.dmemREN), 32'd1);
    check("rl_stall_after", 32'(mif.stall_out), 32'd1);
    check("rl_load_q", mif.dmemload_out, 32'd0);

    // Watchdog: four request cycles without dhit.
    for (int i = 0; i < 4; i++) begin
      check("to_pre", 32'(mif.err_timeout), 32'd0);
      tick();
    end
    check("to_set", 32'(mif.err_timeout), 32'd1);
    mif.dhit = 1'b1;
    mif.advance_in = 1'b1;
    @(negedge clk);
    check("to_sticky_hit", 32'(mif.err_timeout), 32'd1);
    tick();
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mif.dhit = 1'b0;
    mif.advance_in = 1'b0;
    @(negedge clk);
    check("to_sticky_nop", 32'(mif.err_timeout), 32'd1);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("to_cleared", 32'(mif.err_timeout), 32'd0);

    // Halt blocks a store.
    set_op(1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h99);
    @(negedge clk);
    check("halt_wen", 32'(mif.dmemWEN), 32'd0);
    check("halt_stall", 32'(mif.stall_out), 32'd0);
    tick();

`ifdef LLSC_EN
    mif.advance_in = 1'b1;
    mif.dhit = 1'b1;
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    set_op(1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h55);
    @(negedge clk);
    check("sc_ok_wen", 32'(mif.dmemWEN), 32'd1);
    check("sc_ok_result", mif.dmemload_out, 32'd1);
    tick();
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    set_op(1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h66);
    mif.dhit = 1'b0;
    mif.snoop_inv_in = 1'b1;
    mif.snoop_addr_in = 32'h40;
    @(negedge clk);
    check("sc_fail_wen", 32'(mif.dmemWEN), 32'd0);
    check("sc_fail_dhit", 32'(mif.dhit_out), 32'd1);
    check("sc_fail_result", mif.dmemload_out, 32'd0);
    tick();
    mif.snoop_inv_in = 1'b0;
    mif.advance_in = 1'b0;
`else
    mif.dhit = 1'b1;
    set_op(1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h55);
    @(negedge clk);
    check("sc_wen", 32'(mif.dmemWEN), 32'd1);
    check("sc_result", mif.dmemload_out, 32'd1);
    tick();
    mif.dhit = 1'b0;
`endif

    // Random traffic against the model.
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mif.advance_in = 1'b0;
    rst = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    chk_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      adv_seen = mif.advance_in;
      if (!rst) step_model();
      #1;
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        model_reset();
      end
      if (adv_seen) new_instr();
      mif.dhit          = ($urandom_range(0, 2) == 0);
      mif.dmemload      = $urandom;
      mif.snoop_inv_in  = ($urandom_range(0, 5) == 0);
      mif.snoop_addr_in = pool[$urandom_range(0, 3)];
      exp_calc();
      mif.advance_in    = ($urandom_range(0, 3) != 0) && !e_stall;
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
